joy_serial_reader: RTL and testbench
====================================

JOY_SERIAL_READER -- requirements
Module: joy_serial_reader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PLAYERS, 2, number of daisy-chained controllers, legal range 1..4.
- BITS, 12, bits per controller, legal range 4..16.
- CLK_DIV, 24, clk cycles per tick, minimum 2.
- GAP_TICKS, 16, idle ticks between frames.
- FILTER, 1. When 1, a frame is published only if it equals the previous raw frame.
- ACTIVE_LOW, 1. When 1, joy_data is inverted before capture.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock.
- reset, in, 1, asynchronous, active-high.
- en, in, 1, high allows new frames to start.
- joy_data, in, 1, serial data from the controller chain.
- joy_clk, out, 1, shift clock to the controllers.
- joy_load, out, 1, parallel load to the controllers, active-low.
- joystick, out, PLAYERS*BITS, published button states, active-high.
- frame_done, out, 1, one-cycle strobe when joystick updates.
- frame_err, out, 1, one-cycle strobe when FILTER rejects a frame.

Function
REQ-003 Tick generation:
- A free-running counter counts 0..CLK_DIV-1; tick is asserted in the cycle the count equals CLK_DIV-1.
- Every FSM transition occurs only on a tick.
REQ-004 FSM states: IDLE, LOAD, CLK_LO, CLK_HI, PUBLISH, GAP.
REQ-005 IDLE: joy_load=1, joy_clk=1. On a tick with en=1, go to LOAD.
REQ-006 LOAD: joy_load=0 for exactly one tick, then go to CLK_LO with the bit index set to 0.
REQ-007 CLK_LO: joy_clk=0. On the tick, capture (joy_data XOR ACTIVE_LOW) into raw[index], then go to CLK_HI.
REQ-008 CLK_HI: joy_clk=1. On the tick:
- if index < PLAYERS*BITS-1, increment index and go to CLK_LO;
- otherwise go to PUBLISH.
REQ-009 Bit order: the first captured bit is player 0 bit 0. Player p, bit b lives at joystick[p*BITS+b].
REQ-010 PUBLISH lasts one tick. On the exiting tick:
- if FILTER=0, or raw equals prev_raw: load joystick from raw and assert frame_done for that single cycle;
- otherwise leave joystick unchanged and assert frame_err for that single cycle;
- in all cases, prev_raw takes the value of raw.
REQ-011 GAP: joy_load=1, joy_clk=1 for GAP_TICKS ticks, then:
- go to LOAD if en=1;
- otherwise go to IDLE.
- If GAP_TICKS=0, GAP is skipped.
REQ-012 en is sampled only in IDLE and at the end of GAP. Deasserting en mid-frame never truncates the frame.
REQ-013 Frame period with en held at 1 is CLK_DIV*(2 + 2*PLAYERS*BITS + GAP_TICKS) clk cycles.
REQ-014 frame_done and frame_err are never asserted in the same cycle.
REQ-015 The index counter never exceeds PLAYERS*BITS-1. No bit beyond the chain length is captured.
REQ-016 All outputs are registered. joy_clk and joy_load are glitch-free.

Reset
REQ-017 reset asserted clears, immediately and asynchronously:
- FSM to IDLE and the tick counter to 0;
- index, raw and prev_raw to 0;
- joystick to 0;
- joy_clk=1, joy_load=1, frame_done=0, frame_err=0.
REQ-018 When reset is asserted mid-frame, the partial frame is discarded. After reset is released, the first published frame requires two matching frames when FILTER=1.

Structure
REQ-019 Package joy_serial_pkg holds:
- the FSM state enum;
- default parameter constants;
- a function computing the index width as clog2(PLAYERS*BITS).
REQ-020 Tick generation is the sub-module joy_tick_gen, with parameter CLK_DIV, inputs clk and reset, and output tick. No other sub-modules are used.

Verification
REQ-021 Default bench configuration: PLAYERS=2, BITS=12, CLK_DIV=4, GAP_TICKS=2, FILTER=1, ACTIVE_LOW=1.
REQ-022 Directed scenarios:
- Timing. Release reset with en=1. Expect joy_load low for exactly 4 cycles, then 24 joy_clk low pulses of 4 cycles each, and a frame period of 208 cycles.
- Filtered publish. Model returns player0=12'h0A5 and player1=12'h3C0 (active-low on the wire). Expect frame_err in the first frame, frame_done in the second, and joystick=24'h3C00A5.
- Filter reject. Alternate 12'h001 and 12'h002 for player 0 on successive frames. Expect frame_err every frame, frame_done never, and joystick held at its last value.
- FILTER=0. A single frame with player 1 bit 11 set publishes joystick[23]=1 in the first frame.
- en dropped mid-CLK_HI of bit 10. The frame completes, the FSM enters IDLE after GAP, and no LOAD occurs until en=1.
- Reset asserted mid-frame at bit 7. All outputs return to their reset values in the same cycle, and the next frame starts from LOAD.

Source files
------------

// File: rtl/joy_serial_pkg.sv
// Shared types, defaults and sizing helpers for the serial joystick reader.
package joy_serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CLK_LO,
      CLK_HI,
      PUBLISH,
      GAP
   } state_t;

   localparam int DEF_PLAYERS    = 2;
   localparam int DEF_BITS       = 12;
   localparam int DEF_CLK_DIV    = 24;
   localparam int DEF_GAP_TICKS  = 16;
   localparam int DEF_FILTER     = 1;
   localparam int DEF_ACTIVE_LOW = 1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider; tick marks the last clk cycle of each CLK_DIV period.
module joy_tick_gen #(
   parameter int CLK_DIV = 24
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (tick)
         count <= '0;
      else
         count <= count + 1'b1;
   end
endmodule

// File: rtl/joy_serial_reader.sv
// Reads a chain of shift-register game controllers and publishes
// debounced (two matching frames) button states.
module joy_serial_reader
   import joy_serial_pkg::*;
#(
   parameter int PLAYERS    = DEF_PLAYERS,
   parameter int BITS       = DEF_BITS,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int FILTER     = DEF_FILTER,
   parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    joy_data,
   output logic                    joy_clk,
   output logic                    joy_load,
   output logic [PLAYERS*BITS-1:0] joystick,
   output logic                    frame_done,
   output logic                    frame_err
);
   localparam int N  = PLAYERS * BITS;
   localparam int IW = idx_width(N);
   localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
   localparam logic [GW-1:0] GAP_LAST = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;
   localparam logic INVERT = (ACTIVE_LOW != 0);

   state_t         state, state_next;
   logic [IW-1:0]  index;
   logic [N-1:0]   raw, prev_raw;
   logic           prev_valid;
   logic [GW-1:0]  gap_cnt;
   logic           tick;
   logic           last_bit;
   logic           match;

   joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign last_bit = (index == IW'(N - 1));
   // prev_valid makes the first frame after reset always fail the filter.
   assign match = (FILTER == 0) || (prev_valid && (raw == prev_raw));

   always_comb begin
      state_next = state;
      if (tick) begin
         case (state)
            IDLE:    if (en) state_next = LOAD;
            LOAD:    state_next = CLK_LO;
            CLK_LO:  state_next = CLK_HI;
            CLK_HI:  state_next = last_bit ? PUBLISH : CLK_LO;
            PUBLISH: begin
               if (GAP_TICKS == 0)
                  state_next = en ? LOAD : IDLE;
               else
                  state_next = GAP;
            end
            GAP:     if (gap_cnt == GAP_LAST) state_next = en ? LOAD : IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Pins are decoded from state_next so they are registered and line up with state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         index      <= '0;
         raw        <= '0;
         prev_raw   <= '0;
         prev_valid <= 1'b0;
         gap_cnt    <= '0;
         joystick   <= '0;
         joy_clk    <= 1'b1;
         joy_load   <= 1'b1;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_next;
         joy_clk    <= (state_next != CLK_LO);
         joy_load   <= (state_next != LOAD);
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         if (tick) begin
            case (state)
               LOAD:    index <= '0;
               CLK_LO:  raw[index] <= joy_data ^ INVERT;
               CLK_HI:  if (!last_bit) index <= index + 1'b1;
               PUBLISH: begin
                  prev_raw   <= raw;
                  prev_valid <= 1'b1;
                  gap_cnt    <= '0;
                  if (match) begin
                     joystick   <= raw;
                     frame_done <= 1'b1;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end
               GAP:     gap_cnt <= gap_cnt + 1'b1;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench: controller-chain model, table-driven filter vectors, random frames
// against a frame-level model, and directed en/reset corner cases.
module tb_joy_serial_reader;
   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        joy_data;
   logic        joy_clk, joy_load, frame_done, frame_err;
   logic [23:0] joystick;
   logic        nf_clk, nf_load, nf_done, nf_err;
   logic [23:0] nf_joy;

   int compared   = 0;
   int mismatched = 0;
   int frame_no   = 0;

   always #5 clk = ~clk;

   joy_serial_reader #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .GAP_TICKS(2),
                       .FILTER(1), .ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .en(en), .joy_data(joy_data),
      .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick),
      .frame_done(frame_done), .frame_err(frame_err));

   joy_serial_reader #(.PLAYERS(2), .BITS(12), .CLK_DIV(4), .GAP_TICKS(2),
                       .FILTER(0), .ACTIVE_LOW(1)) dut_nf (
      .clk(clk), .reset(reset), .en(en), .joy_data(joy_data),
      .joy_clk(nf_clk), .joy_load(nf_load), .joystick(nf_joy),
      .frame_done(nf_done), .frame_err(nf_err));

   // Controller chain: parallel load while joy_load is low, shift on joy_clk rise,
   // buttons are driven active-low on the wire.
   logic [23:0] pad;
   logic [23:0] shreg = '0;
   logic [5:0]  ptr = '0;
   logic        pclk = 1'b1;

   always @(posedge clk) begin
      if (!joy_load) begin
         shreg <= pad;
         ptr   <= '0;
      end else if (joy_clk && !pclk && ptr < 6'd24) begin
         ptr <= ptr + 6'd1;
      end
      pclk <= joy_clk;
   end

   always_comb begin
      joy_data = 1'b1;
      if (ptr < 6'd24) joy_data = ~shreg[ptr[4:0]];
   end

   // Frame-level reference: publish only when a frame repeats the previous one.
   logic [23:0] m_prev;
   logic        m_valid;
   logic [23:0] m_joy;

   task automatic model_publish(input logic [23:0] frame, output logic exp_done);
      exp_done = m_valid && (frame == m_prev);
      if (exp_done) m_joy = frame;
      m_prev  = frame;
      m_valid = 1'b1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: actual %0h, required %0h", name, act, req);
      end
   endtask

   logic ev_done, ev_err, ev_ok, ev_nf_done;
   logic [23:0] ev_joy, ev_nf_joy;

   task automatic wait_publish();
      ev_ok = 1'b0; ev_done = 1'b0; ev_err = 1'b0; ev_nf_done = 1'b0;
      for (int i = 0; i < 600 && !ev_ok; i++) begin
         @(negedge clk);
         if (frame_done || frame_err) begin
            ev_ok      = 1'b1;
            ev_done    = frame_done;
            ev_err     = frame_err;
            ev_joy     = joystick;
            ev_nf_done = nf_done;
            ev_nf_joy  = nf_joy;
         end
      end
      frame_no++;
      check("publish_timeout", 64'(ev_ok), 64'd1);
      check("done_err_exclusive", 64'(ev_done & ev_err), 64'd0);
      $display("frame %0d: pad=%h done=%b err=%b joystick=%h nf_joystick=%h",
               frame_no, pad, ev_done, ev_err, ev_joy, ev_nf_joy);
   endtask

   task automatic check_model_frame(input string name);
      logic exp_done;
      model_publish(pad, exp_done);
      wait_publish();
      check({name, "_kind"}, 64'({ev_done, ev_err}), 64'({exp_done, ~exp_done}));
      check({name, "_joy"}, 64'(ev_joy), 64'(m_joy));
      check({name, "_nf_joy"}, 64'({ev_nf_done, ev_nf_joy}), 64'({1'b1, pad}));
   endtask

   task automatic wait_lo_start(input int n, output logic ok);
      int   cnt = 0;
      logic seen = 1'b0;
      logic pc = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
         @(negedge clk);
         if (!joy_load) seen = 1'b1;
         else if (seen && !joy_clk && pc) begin
            cnt++;
            if (cnt == n) ok = 1'b1;
         end
         pc = joy_clk;
      end
   endtask

   task automatic check_timing();
      int   cyc = 0;
      int   falls[$];
      int   load_len = 0, lo_pulses = 0, bad_width = 0, lo_run = 0;
      logic pl = 1'b1, pc = 1'b1;
      while (cyc < 700 && falls.size() < 2) begin
         @(negedge clk);
         cyc++;
         if (!joy_load && pl) falls.push_back(cyc);
         if (!joy_load && falls.size() == 1) load_len++;
         if (!joy_clk) lo_run++;
         else begin
            if (!pc && falls.size() == 1) begin
               lo_pulses++;
               if (lo_run != 4) bad_width++;
            end
            lo_run = 0;
         end
         pl = joy_load;
         pc = joy_clk;
      end
      check("timing_two_loads", 64'(falls.size()), 64'd2);
      if (falls.size() == 2) begin
         check("timing_first_load", 64'(falls[0]), 64'd4);
         check("timing_period", 64'(falls[1] - falls[0]), 64'd208);
      end
      check("timing_load_len", 64'(load_len), 64'd4);
      check("timing_clk_pulses", 64'(lo_pulses), 64'd24);
      check("timing_clk_width", 64'(bad_width), 64'd0);
      $display("timing: load_len=%0d clk_pulses=%0d bad_widths=%0d", load_len, lo_pulses, bad_width);
   endtask

   typedef struct {
      logic [23:0] pad;
      logic        done;
      logic [23:0] joy;
   } vec_t;

   vec_t tbl[10];

   initial begin
      logic ok;
      int   idle_loads;
      int   wait_cyc;

      tbl[0] = '{24'h3C00A5, 1'b0, 24'h000000};
      tbl[1] = '{24'h3C00A5, 1'b1, 24'h3C00A5};
      tbl[2] = '{24'h000001, 1'b0, 24'h3C00A5};
      tbl[3] = '{24'h000002, 1'b0, 24'h3C00A5};
      tbl[4] = '{24'h000001, 1'b0, 24'h3C00A5};
      tbl[5] = '{24'h000002, 1'b0, 24'h3C00A5};
      tbl[6] = '{24'hFFF000, 1'b0, 24'h3C00A5};
      tbl[7] = '{24'hFFF000, 1'b1, 24'hFFF000};
      tbl[8] = '{24'h555AAA, 1'b0, 24'hFFF000};
      tbl[9] = '{24'h555AAA, 1'b1, 24'h555AAA};

      reset = 1'b1; en = 1'b1; pad = '0;
      repeat (3) @(negedge clk);
      check("reset_state", 64'({joystick, joy_clk, joy_load, frame_done, frame_err}),
            64'({24'h0, 4'b1100}));
      reset = 1'b0;
      check_timing();

      // Filter vectors from a fresh reset.
      pad = tbl[0].pad;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_publish();
         check($sformatf("tbl%0d_kind", i), 64'({ev_done, ev_err}), 64'({tbl[i].done, ~tbl[i].done}));
         check($sformatf("tbl%0d_joy", i), 64'(ev_joy), 64'(tbl[i].joy));
         check($sformatf("tbl%0d_nf", i), 64'({ev_nf_done, ev_nf_joy}), 64'({1'b1, tbl[i].pad}));
         if (i < 9) pad = tbl[i+1].pad;
      end

      // Random frames, with frequent repeats so both outcomes occur.
      m_prev = tbl[9].pad; m_valid = 1'b1; m_joy = tbl[9].joy;
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) != 0) pad = 24'($urandom);
         check_model_frame("rand");
      end

      // en dropped in CLK_HI of bit 10: frame still completes, then IDLE.
      pad = 24'h123456;
      check_model_frame("en_pre");
      wait_lo_start(11, ok);
      check("en_bit10_reached", 64'(ok), 64'd1);
      repeat (5) @(negedge clk);
      en = 1'b0;
      check_model_frame("en_drop");
      check("en_drop_published", 64'(ev_joy), 64'h123456);
      idle_loads = 0;
      repeat (300) begin
         @(negedge clk);
         if (!joy_load) idle_loads++;
      end
      check("idle_no_load", 64'(idle_loads), 64'd0);
      en = 1'b1;
      wait_cyc = 0;
      while (joy_load && wait_cyc < 20) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("en_restart_load", 64'(joy_load), 64'd0);

      // Reset in CLK_LO of bit 7: outputs clear at once.
      wait_lo_start(8, ok);
      check("reset_bit7_reached", 64'(ok), 64'd1);
      reset = 1'b1;
      #1;
      check("midframe_reset", 64'({joystick, joy_clk, joy_load, frame_done, frame_err}),
            64'({24'h0, 4'b1100}));
      check("midframe_reset_nf", 64'({nf_joy, nf_clk, nf_load, nf_done, nf_err}),
            64'({24'h0, 4'b1100}));
      pad = 24'h800000;
      m_valid = 1'b0; m_joy = '0;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc = 0;
      while (joy_load && wait_cyc < 40) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("post_reset_load_at", 64'(wait_cyc), 64'd4);
      check_model_frame("post_reset1");
      check("nf_first_frame_bit23", 64'({ev_nf_done, ev_nf_joy[23]}), 64'b11);
      check_model_frame("post_reset2");
      check("post_reset2_joy", 64'(ev_joy), 64'h800000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
